// File: rtl/btn_input_port_if.sv
// Bus bundle between the CPU read logic and the button input port.
// The slave side is the port itself; the master side is the CPU (or a bench).
interface btn_input_port_if;
  logic        btn;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        btn_level;
  logic        btn_press;
  logic        btn_release;

  modport slave (
    input  btn,
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output rd_valid,
    output btn_level,
    output btn_press,
    output btn_release
  );

  modport master (
    output btn,
    output rd_en,
    output rd_addr,
    input  rd_data,
    input  rd_valid,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );
endinterface

// File: rtl/btn_input_port.sv
// Button input port: synchronises and debounces the raw button, pulses on
// accepted edges, counts presses and exposes level/flags/count to the CPU.
module btn_input_port #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int EVT_W           = 4
) (
  input logic              clk,
  input logic              reset,
  btn_input_port_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE_LO,
    WAIT_HI,
    IDLE_HI,
    WAIT_LO
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             btnSync_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             btnLevel_q;
  logic             btnPress_q;
  logic             btnRelease_q;

  logic [EVT_W-1:0] pressCount_q, pressCount_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic [31:0]      rdData_q, rdData_d;
  logic             rdValid_q, rdValid_d;
  logic             clearFlags;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      btnSync_q <= 1'b0;
    end else begin
      s1_q      <= bus.btn;
      btnSync_q <= s1_q;
    end
  end

  // A level change is only accepted after btn_sync has held the new value
  // through the whole wait state; any flicker drops back to the idle state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE_LO;
      cnt_q        <= '0;
      btnLevel_q   <= 1'b0;
      btnPress_q   <= 1'b0;
      btnRelease_q <= 1'b0;
    end else begin
      btnPress_q   <= 1'b0;
      btnRelease_q <= 1'b0;
      case (state_q)
        IDLE_LO: begin
          if (btnSync_q) begin
            state_q <= WAIT_HI;
            cnt_q   <= '0;
          end
        end
        WAIT_HI: begin
          if (!btnSync_q) begin
            state_q <= IDLE_LO;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= IDLE_HI;
            btnLevel_q <= 1'b1;
            btnPress_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE_HI: begin
          if (!btnSync_q) begin
            state_q <= WAIT_LO;
            cnt_q   <= '0;
          end
        end
        WAIT_LO: begin
          if (btnSync_q) begin
            state_q <= IDLE_HI;
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= IDLE_LO;
            btnLevel_q   <= 1'b0;
            btnRelease_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE_LO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign clearFlags = bus.rd_en && (bus.rd_addr == 2'd1);

  // A press arriving with a clearing read still leaves pending set; the
  // overrun only survives if the press found pending already set and uncleared.
  always_comb begin
    pressCount_d = pressCount_q + EVT_W'(btnPress_q);
    pending_d    = btnPress_q | (pending_q & ~clearFlags);
    overrun_d    = (btnPress_q & pending_q & ~clearFlags) | (overrun_q & ~clearFlags);
    rdValid_d    = bus.rd_en;
    rdData_d     = rdData_q;
    if (bus.rd_en) begin
      case (bus.rd_addr)
        2'd0:    rdData_d = {31'b0, btnLevel_q};
        2'd1:    rdData_d = {30'b0, overrun_q, pending_q};
        2'd2:    rdData_d = {{(32-EVT_W){1'b0}}, pressCount_q};
        default: rdData_d = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pressCount_q <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      rdData_q     <= 32'b0;
      rdValid_q    <= 1'b0;
    end else begin
      pressCount_q <= pressCount_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      rdData_q     <= rdData_d;
      rdValid_q    <= rdValid_d;
    end
  end

  assign bus.rd_data     = rdData_q;
  assign bus.rd_valid    = rdValid_q;
  assign bus.btn_level   = btnLevel_q;
  assign bus.btn_press   = btnPress_q;
  assign bus.btn_release = btnRelease_q;

endmodule
